// File: rtl/csi2tx_dphy_rst_seq.sv
// Reset sequencer and byte-clock generator for the CSI-2 TX D-PHY model:
// stabilisation wait, staggered lane-reset release, drain on disable, divide-by-DIV byte clock.
module csi2tx_dphy_rst_seq #(
   parameter int unsigned NUM_LANES   = 8,
   parameter int unsigned DIV         = 4,
   parameter int unsigned STABLE_CYC  = 16,
   parameter int unsigned STAGGER_CYC = 4,
   parameter int unsigned DRAIN_CYC   = 8
) (
   input  logic                 txddrclkhs_i,
   input  logic                 pwr_on_rst,
   input  logic                 enable,
   input  logic [NUM_LANES-1:0] lane_en,
   output logic                 tx_byte_rst_n,
   output logic [NUM_LANES-1:0] lane_rst_n,
   output logic                 txbyteclkhs,
   output logic                 byte_clk_en,
   output logic                 ready,
   output logic [2:0]           seq_state
);

   localparam int unsigned DW = $clog2(DIV);
   localparam int unsigned SW = $clog2(STABLE_CYC + 1);
   localparam int unsigned GW = $clog2(STAGGER_CYC + 1);
   localparam int unsigned RW = $clog2(DRAIN_CYC + 1);

   localparam logic [DW-1:0] DIV_LAST    = DW'(DIV - 1);
   localparam logic [DW-1:0] DIV_HALF    = DW'(DIV / 2);
   localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYC - 1);
   localparam logic [GW-1:0] STAG_LAST   = GW'(STAGGER_CYC - 1);
   localparam logic [RW-1:0] DRAIN_LAST  = RW'(DRAIN_CYC - 1);

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      WAIT_STABLE = 3'd1,
      RELEASE     = 3'd2,
      ACTIVE      = 3'd3,
      DRAIN       = 3'd4
   } state_t;

   state_t               state;
   logic [NUM_LANES-1:0] lane_en_q;
   logic [SW-1:0]        wait_cnt;
   logic [GW-1:0]        stag_cnt;
   logic [RW-1:0]        drain_cnt;
   logic [DW-1:0]        div_cnt;

   logic [NUM_LANES-1:0] pending;
   logic [NUM_LANES-1:0] next_lane;
   logic                 last_lane;

   // Lowest still-held enabled lane is the next to release; disabled lanes never enter pending.
   always_comb begin
      pending   = lane_en_q & ~lane_rst_n;
      next_lane = pending & (~pending + NUM_LANES'(1));
      last_lane = ((pending & ~next_lane) == '0);
   end

   always_ff @(posedge txddrclkhs_i) begin
      if (!pwr_on_rst) begin
         state         <= IDLE;
         lane_en_q     <= '0;
         wait_cnt      <= '0;
         stag_cnt      <= '0;
         drain_cnt     <= '0;
         div_cnt       <= '0;
         tx_byte_rst_n <= 1'b0;
         lane_rst_n    <= '0;
         ready         <= 1'b0;
      end else begin
         if (tx_byte_rst_n)
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
         else
            div_cnt <= '0;

         case (state)
            IDLE: begin
               if (enable) begin
                  lane_en_q <= lane_en;
                  wait_cnt  <= '0;
                  state     <= WAIT_STABLE;
               end
            end
            WAIT_STABLE: begin
               if (!enable) begin
                  state <= IDLE;
               end else if (wait_cnt == STABLE_LAST) begin
                  tx_byte_rst_n <= 1'b1;
                  stag_cnt      <= '0;
                  if (lane_en_q == '0) begin
                     state <= ACTIVE;
                     ready <= 1'b1;
                  end else begin
                     state <= RELEASE;
                  end
               end else begin
                  wait_cnt <= wait_cnt + SW'(1);
               end
            end
            RELEASE: begin
               if (!enable) begin
                  lane_rst_n <= '0;
                  ready      <= 1'b0;
                  drain_cnt  <= '0;
                  state      <= DRAIN;
               end else if (stag_cnt == STAG_LAST) begin
                  lane_rst_n <= lane_rst_n | next_lane;
                  stag_cnt   <= '0;
                  if (last_lane) begin
                     state <= ACTIVE;
                     ready <= 1'b1;
                  end
               end else begin
                  stag_cnt <= stag_cnt + GW'(1);
               end
            end
            ACTIVE: begin
               if (!enable) begin
                  lane_rst_n <= '0;
                  ready      <= 1'b0;
                  drain_cnt  <= '0;
                  state      <= DRAIN;
               end
            end
            DRAIN: begin
               // Clearing div_cnt here keeps it at 0 from the cycle tx_byte_rst_n falls.
               if (drain_cnt == DRAIN_LAST) begin
                  tx_byte_rst_n <= 1'b0;
                  div_cnt       <= '0;
                  state         <= IDLE;
               end else begin
                  drain_cnt <= drain_cnt + RW'(1);
               end
            end
            default: begin
               state         <= IDLE;
               tx_byte_rst_n <= 1'b0;
               lane_rst_n    <= '0;
               ready         <= 1'b0;
               div_cnt       <= '0;
            end
         endcase
      end
   end

   always_comb begin
      txbyteclkhs = tx_byte_rst_n && (div_cnt < DIV_HALF);
      byte_clk_en = tx_byte_rst_n && (div_cnt == '0);
      seq_state   = state;
   end

endmodule

// File: tb/tb_csi2tx_dphy_rst_seq.sv
// Directed bench for csi2tx_dphy_rst_seq: default instance plus a DIV=6 instance on shared inputs.
module tb_csi2tx_dphy_rst_seq;

  logic       clk = 1'b0;
  logic       pwr_on_rst = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] lane_en = '0;

  logic       tx_byte_rst_n, txbyteclkhs, byte_clk_en, ready;
  logic [7:0] lane_rst_n;
  logic [2:0] seq_state;

  logic       tx_byte_rst_n_6, txbyteclkhs_6, byte_clk_en_6, ready_6;
  logic [7:0] lane_rst_n_6;
  logic [2:0] seq_state_6;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  csi2tx_dphy_rst_seq dut (
    .txddrclkhs_i (clk),
    .pwr_on_rst   (pwr_on_rst),
    .enable       (enable),
    .lane_en      (lane_en),
    .tx_byte_rst_n(tx_byte_rst_n),
    .lane_rst_n   (lane_rst_n),
    .txbyteclkhs  (txbyteclkhs),
    .byte_clk_en  (byte_clk_en),
    .ready        (ready),
    .seq_state    (seq_state)
  );

  csi2tx_dphy_rst_seq #(.DIV(6)) dut6 (
    .txddrclkhs_i (clk),
    .pwr_on_rst   (pwr_on_rst),
    .enable       (enable),
    .lane_en      (lane_en),
    .tx_byte_rst_n(tx_byte_rst_n_6),
    .lane_rst_n   (lane_rst_n_6),
    .txbyteclkhs  (txbyteclkhs_6),
    .byte_clk_en  (byte_clk_en_6),
    .ready        (ready_6),
    .seq_state    (seq_state_6)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    pwr_on_rst = 1'b0;
    enable     = 1'b0;
    lane_en    = '0;
    tick();
    tick();
    pwr_on_rst = 1'b1;
  endtask

  // Expected lane mask k edges after E1: n-th enabled lane releases at 16+4n.
  function automatic logic [7:0] exp_lanes(int k, logic [7:0] m);
    int n = 0;
    exp_lanes = '0;
    for (int unsigned i = 0; i < 8; i++)
      if (m[i]) begin
        n++;
        if (k >= 16 + 4 * n) exp_lanes[i] = 1'b1;
      end
  endfunction

  function automatic int ready_k(logic [7:0] m);
    return 16 + 4 * $countones(m);
  endfunction

  function automatic logic [2:0] exp_state(int k, logic [7:0] m);
    if (k < 16) return 3'd1;
    if (k < ready_k(m)) return 3'd2;
    return 3'd3;
  endfunction

  task automatic test_reset();
    tick();
    vecs++;
    if ({tx_byte_rst_n, lane_rst_n, txbyteclkhs, byte_clk_en, ready, seq_state} !== 14'h0) begin
      errs++;
      $display("FAIL reset got %h want 0",
               {tx_byte_rst_n, lane_rst_n, txbyteclkhs, byte_clk_en, ready, seq_state});
    end
    vecs++;
    if ({tx_byte_rst_n_6, lane_rst_n_6, txbyteclkhs_6, byte_clk_en_6, ready_6, seq_state_6} !== 14'h0) begin
      errs++;
      $display("FAIL reset_div6 got %h want 0",
               {tx_byte_rst_n_6, lane_rst_n_6, txbyteclkhs_6, byte_clk_en_6, ready_6, seq_state_6});
    end
  endtask

  // All lanes enabled; also checks both dividers (DIV=4 and DIV=6) every cycle after release.
  task automatic test_full_lanes();
    logic [1:0] e4, e6;
    apply_reset();
    lane_en = 8'hFF;
    enable  = 1'b1;
    tick();
    vecs++;
    if (seq_state !== 3'd1) begin
      errs++;
      $display("FAIL full_e1_state got %0d want 1", seq_state);
    end
    for (int k = 1; k <= 60; k++) begin
      tick();
      vecs++;
      if (tx_byte_rst_n !== (k >= 16)) begin
        errs++;
        $display("FAIL full_byte_rst k=%0d got %b want %b", k, tx_byte_rst_n, k >= 16);
      end
      vecs++;
      if (lane_rst_n !== exp_lanes(k, 8'hFF)) begin
        errs++;
        $display("FAIL full_lanes k=%0d got %h want %h", k, lane_rst_n, exp_lanes(k, 8'hFF));
      end
      vecs++;
      if (ready !== (k >= 48)) begin
        errs++;
        $display("FAIL full_ready k=%0d got %b want %b", k, ready, k >= 48);
      end
      vecs++;
      if (seq_state !== exp_state(k, 8'hFF)) begin
        errs++;
        $display("FAIL full_state k=%0d got %0d want %0d", k, seq_state, exp_state(k, 8'hFF));
      end
      e4 = (k >= 16) ? {((k - 16) % 4) < 2, ((k - 16) % 4) == 0} : 2'b00;
      e6 = (k >= 16) ? {((k - 16) % 6) < 3, ((k - 16) % 6) == 0} : 2'b00;
      vecs++;
      if ({txbyteclkhs, byte_clk_en} !== e4) begin
        errs++;
        $display("FAIL div4 k=%0d got %b want %b", k, {txbyteclkhs, byte_clk_en}, e4);
      end
      vecs++;
      if ({txbyteclkhs_6, byte_clk_en_6} !== e6) begin
        errs++;
        $display("FAIL div6 k=%0d got %b want %b", k, {txbyteclkhs_6, byte_clk_en_6}, e6);
      end
    end
  endtask

  // Continues from ACTIVE at k=60 left by test_full_lanes.
  task automatic test_drain();
    logic [1:0] e4, e6;
    enable = 1'b0;
    tick();
    vecs++;
    if ({lane_rst_n, ready, seq_state, tx_byte_rst_n} !== {8'h00, 1'b0, 3'd4, 1'b1}) begin
      errs++;
      $display("FAIL drain_entry got %h want %h",
               {lane_rst_n, ready, seq_state, tx_byte_rst_n}, {8'h00, 1'b0, 3'd4, 1'b1});
    end
    enable = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      tick();
      vecs++;
      if (tx_byte_rst_n !== (j < 8)) begin
        errs++;
        $display("FAIL drain_byte_rst j=%0d got %b want %b", j, tx_byte_rst_n, j < 8);
      end
      vecs++;
      if (seq_state !== ((j < 8) ? 3'd4 : 3'd0)) begin
        errs++;
        $display("FAIL drain_state j=%0d got %0d want %0d", j, seq_state, (j < 8) ? 4 : 0);
      end
      vecs++;
      if ({lane_rst_n, ready} !== 9'h0) begin
        errs++;
        $display("FAIL drain_lanes j=%0d got %h want 0", j, {lane_rst_n, ready});
      end
      e4 = (j < 8) ? {((45 + j) % 4) < 2, ((45 + j) % 4) == 0} : 2'b00;
      e6 = (j < 8) ? {((45 + j) % 6) < 3, ((45 + j) % 6) == 0} : 2'b00;
      vecs++;
      if ({txbyteclkhs, byte_clk_en} !== e4) begin
        errs++;
        $display("FAIL drain_div4 j=%0d got %b want %b", j, {txbyteclkhs, byte_clk_en}, e4);
      end
      vecs++;
      if ({txbyteclkhs_6, byte_clk_en_6} !== e6) begin
        errs++;
        $display("FAIL drain_div6 j=%0d got %b want %b", j, {txbyteclkhs_6, byte_clk_en_6}, e6);
      end
    end
    tick();
    vecs++;
    if ({seq_state, tx_byte_rst_n} !== {3'd1, 1'b0}) begin
      errs++;
      $display("FAIL drain_reenable got %h want %h", {seq_state, tx_byte_rst_n}, {3'd1, 1'b0});
    end
  endtask

  task automatic test_sparse_lanes();
    apply_reset();
    lane_en = 8'h05;
    enable  = 1'b1;
    tick();
    for (int k = 1; k <= 30; k++) begin
      if (k == 26) lane_en = 8'hFF;
      tick();
      vecs++;
      if (lane_rst_n !== exp_lanes(k, 8'h05)) begin
        errs++;
        $display("FAIL sparse_lanes k=%0d got %h want %h", k, lane_rst_n, exp_lanes(k, 8'h05));
      end
      vecs++;
      if (ready !== (k >= 24)) begin
        errs++;
        $display("FAIL sparse_ready k=%0d got %b want %b", k, ready, k >= 24);
      end
      vecs++;
      if (seq_state !== exp_state(k, 8'h05)) begin
        errs++;
        $display("FAIL sparse_state k=%0d got %0d want %0d", k, seq_state, exp_state(k, 8'h05));
      end
    end
  endtask

  task automatic test_no_lanes();
    apply_reset();
    lane_en = 8'h00;
    enable  = 1'b1;
    tick();
    for (int k = 1; k <= 20; k++) begin
      tick();
      vecs++;
      if ({tx_byte_rst_n, ready} !== {2{k >= 16}}) begin
        errs++;
        $display("FAIL nolane_rst_ready k=%0d got %b want %b", k, {tx_byte_rst_n, ready}, {2{k >= 16}});
      end
      vecs++;
      if (lane_rst_n !== 8'h00) begin
        errs++;
        $display("FAIL nolane_lanes k=%0d got %h want 00", k, lane_rst_n);
      end
      vecs++;
      if (seq_state !== ((k >= 16) ? 3'd3 : 3'd1)) begin
        errs++;
        $display("FAIL nolane_state k=%0d got %0d want %0d", k, seq_state, (k >= 16) ? 3 : 1);
      end
    end
  endtask

  task automatic test_reset_mid_release();
    apply_reset();
    lane_en = 8'hFF;
    enable  = 1'b1;
    tick();
    repeat (20) tick();
    vecs++;
    if ({lane_rst_n, seq_state} !== {8'h01, 3'd2}) begin
      errs++;
      $display("FAIL midrel_pre got %h want %h", {lane_rst_n, seq_state}, {8'h01, 3'd2});
    end
    pwr_on_rst = 1'b0;
    tick();
    vecs++;
    if ({tx_byte_rst_n, lane_rst_n, txbyteclkhs, byte_clk_en, ready, seq_state} !== 14'h0) begin
      errs++;
      $display("FAIL midrel_reset got %h want 0",
               {tx_byte_rst_n, lane_rst_n, txbyteclkhs, byte_clk_en, ready, seq_state});
    end
    pwr_on_rst = 1'b1;
    tick();
    vecs++;
    if ({seq_state, tx_byte_rst_n} !== {3'd1, 1'b0}) begin
      errs++;
      $display("FAIL midrel_e1 got %h want %h", {seq_state, tx_byte_rst_n}, {3'd1, 1'b0});
    end
    repeat (16) tick();
    vecs++;
    if ({tx_byte_rst_n, seq_state, lane_rst_n, byte_clk_en} !== {1'b1, 3'd2, 8'h00, 1'b1}) begin
      errs++;
      $display("FAIL midrel_byte got %h want %h",
               {tx_byte_rst_n, seq_state, lane_rst_n, byte_clk_en}, {1'b1, 3'd2, 8'h00, 1'b1});
    end
    repeat (4) tick();
    vecs++;
    if (lane_rst_n !== 8'h01) begin
      errs++;
      $display("FAIL midrel_lane0 got %h want 01", lane_rst_n);
    end
  endtask

  initial begin
    test_reset();
    test_full_lanes();
    test_drain();
    test_sparse_lanes();
    test_no_lanes();
    test_reset_mid_release();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
